// File: rtl/bus_wait_slave.sv
// Register-file bus slave that answers each request after WAIT_CYCLES wait states.
// Optional BUS_WAIT_SLAVE_STATUS_EN: top address reads a completed-transaction counter.
module bus_wait_slave #(
  parameter int WAIT_CYCLES = 2,
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid,
  input  logic              write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [DATA_W:0]   bus_out
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_wdata;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] stat_val;

`ifdef BUS_WAIT_SLAVE_STATUS_EN
  localparam bit STAT_EN = 1'b1;
  logic [DATA_W-1:0] stat_cnt;
  assign stat_val = stat_cnt;

  // One increment per ready pulse; RESP is exactly the ready cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_cnt <= '0;
    end else if (state == RESP) begin
      stat_cnt <= stat_cnt + DATA_W'(1);
    end
  end
`else
  localparam bit STAT_EN = 1'b0;
  assign stat_val = '0;
`endif

  function automatic logic [DATA_W-1:0] resp_data(input logic              wr,
                                                  input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] wd,
                                                  input logic [DATA_W-1:0] word,
                                                  input logic [DATA_W-1:0] sv);
    if (wr) return wd;
    if (STAT_EN && (a == STAT_ADDR)) return sv;
    return word;
  endfunction

  function automatic logic stores(input logic wr, input logic [ADDR_W-1:0] a);
    return wr && !(STAT_EN && (a == STAT_ADDR));
  endfunction

  // ready/rdata are registered on entry to RESP, so they are high exactly in RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rdata     <= '0;
      ready     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready <= 1'b0;
      rdata <= '0;
      case (state)
        IDLE: begin
          if (valid) begin
            cap_write <= write;
            cap_addr  <= addr;
            cap_wdata <= wdata;
            cnt       <= CNT_W'(WAIT_CYCLES);
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
              ready <= 1'b1;
              rdata <= resp_data(write, addr, wdata, mem[addr], stat_val);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= RESP;
            ready <= 1'b1;
            rdata <= resp_data(cap_write, cap_addr, cap_wdata, mem[cap_addr], stat_val);
          end
        end
        RESP: begin
          state <= IDLE;
          if (stores(cap_write, cap_addr)) mem[cap_addr] <= cap_wdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_out <= '0;
    end else begin
      bus_out <= {ready, rdata};
    end
  end

endmodule

// File: tb/tb_bus_wait_slave.sv
// Scoreboard bench for bus_wait_slave: a WAIT_CYCLES=2 instance and a WAIT_CYCLES=0 instance.
module tb_bus_wait_slave;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       valid_s   [2];
  logic       write_s   [2];
  logic [3:0] addr_s    [2];
  logic [3:0] wdata_s   [2];
  logic [3:0] rdata_s   [2];
  logic       ready_s   [2];
  logic [4:0] bus_out_s [2];

  int tests = 0;
  int fails = 0;

  logic [3:0] mdl  [2][16];
  logic [3:0] mcnt [2];
  logic [3:0] expq [$];
  logic [3:0] last_exp;

`ifdef BUS_WAIT_SLAVE_STATUS_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif

  bus_wait_slave #(.WAIT_CYCLES(2), .ADDR_W(4), .DATA_W(4)) u_w2 (
    .clk(clk), .rst_n(rst_n), .valid(valid_s[0]), .write(write_s[0]),
    .addr(addr_s[0]), .wdata(wdata_s[0]), .rdata(rdata_s[0]),
    .ready(ready_s[0]), .bus_out(bus_out_s[0])
  );

  bus_wait_slave #(.WAIT_CYCLES(0), .ADDR_W(4), .DATA_W(4)) u_w0 (
    .clk(clk), .rst_n(rst_n), .valid(valid_s[1]), .write(write_s[1]),
    .addr(addr_s[1]), .wdata(wdata_s[1]), .rdata(rdata_s[1]),
    .ready(ready_s[1]), .bus_out(bus_out_s[1])
  );

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 16; a++) mdl[d][a] = 4'h0;
      mcnt[d] = 4'h0;
    end
    expq.delete();
  endtask

  // Drive a request and push the response the slave owes for it.
  task automatic start_req(input int d, input logic wr, input logic [3:0] a, input logic [3:0] wd);
    logic [3:0] e;
    if (wr) e = wd;
    else if (STAT && a == 4'hF) e = mcnt[d];
    else e = mdl[d][a];
    expq.push_back(e);
    if (wr && !(STAT && a == 4'hF)) mdl[d][a] = wd;
    mcnt[d] = mcnt[d] + 4'h1;
    valid_s[d] = 1'b1;
    write_s[d] = wr;
    addr_s[d]  = a;
    wdata_s[d] = wd;
  endtask

  // Next edge is the accept edge; lat counts cycles from the accept cycle to ready.
  task automatic finish_req(input int d, input int exp_lat, input bit scramble, input string nm);
    int lat;
    bit seen;
    @(posedge clk); #1;
    lat = 1;
    seen = 1'b0;
    if (scramble) begin
      valid_s[d] = 1'b0;
      write_s[d] = ~write_s[d];
      addr_s[d]  = addr_s[d] + 4'd5;
      wdata_s[d] = ~wdata_s[d];
    end
    while (lat <= 30) begin
      if (ready_s[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    last_exp = (expq.size() > 0) ? expq.pop_front() : 4'hx;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL %s_timeout ready not seen within 30 cycles", nm);
    end else begin
      tests++;
      if (rdata_s[d] !== last_exp) begin
        fails++;
        $display("FAIL %s_rdata got %h want %h", nm, rdata_s[d], last_exp);
      end
      tests++;
      if (lat !== exp_lat) begin
        fails++;
        $display("FAIL %s_latency got %0d want %0d", nm, lat, exp_lat);
      end
    end
  endtask

  task automatic end_req(input int d, input string nm);
    valid_s[d] = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (ready_s[d] !== 1'b0) begin
      fails++;
      $display("FAIL %s_pulse ready got %b want 0", nm, ready_s[d]);
    end
    tests++;
    if (bus_out_s[d] !== {1'b1, last_exp}) begin
      fails++;
      $display("FAIL %s_bus_out got %h want %h", nm, bus_out_s[d], {1'b1, last_exp});
    end
    @(posedge clk); #1;
    tests++;
    if (bus_out_s[d] !== 5'h00) begin
      fails++;
      $display("FAIL %s_bus_out_idle got %h want 00", nm, bus_out_s[d]);
    end
  endtask

  task automatic txn(input int d, input logic wr, input logic [3:0] a, input logic [3:0] wd,
                     input string nm);
    start_req(d, wr, a, wd);
    finish_req(d, (d == 0) ? 3 : 1, 1'b0, nm);
    end_req(d, nm);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      valid_s[d] = 1'b0; write_s[d] = 1'b0; addr_s[d] = 4'h0; wdata_s[d] = 4'h0;
    end
    #22;
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (ready_s[d] !== 1'b0) begin
        fails++; $display("FAIL reset_ready dut%0d got %b want 0", d, ready_s[d]);
      end
      tests++;
      if (rdata_s[d] !== 4'h0) begin
        fails++; $display("FAIL reset_rdata dut%0d got %h want 0", d, rdata_s[d]);
      end
      tests++;
      if (bus_out_s[d] !== 5'h00) begin
        fails++; $display("FAIL reset_bus_out dut%0d got %h want 00", d, bus_out_s[d]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    txn(0, 1'b1, 4'h3, 4'hA, "wr3");
    txn(0, 1'b0, 4'h3, 4'h0, "rd3");
    txn(0, 1'b0, 4'h5, 4'h0, "rd5");
  endtask

  task automatic test_zero_wait();
    txn(1, 1'b1, 4'h2, 4'h6, "z_wr2");
    txn(1, 1'b0, 4'h2, 4'h0, "z_rd2");
  endtask

  task automatic test_back_to_back();
    start_req(1, 1'b1, 4'h7, 4'h5);
    finish_req(1, 1, 1'b0, "b2b_wr");
    start_req(1, 1'b0, 4'h7, 4'h0);
    @(posedge clk); #1;
    tests++;
    if (ready_s[1] !== 1'b0) begin
      fails++; $display("FAIL b2b_gap ready got %b want 0", ready_s[1]);
    end
    tests++;
    if (bus_out_s[1] !== 5'h15) begin
      fails++; $display("FAIL b2b_gap_bus_out got %h want 15", bus_out_s[1]);
    end
    finish_req(1, 1, 1'b0, "b2b_rd");
    end_req(1, "b2b_rd");
  endtask

  task automatic test_hold();
    int extra;
    start_req(0, 1'b1, 4'h4, 4'hC);
    finish_req(0, 3, 1'b1, "hold_wr");
    end_req(0, "hold_wr");
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      if (ready_s[0] === 1'b1) extra++;
      @(posedge clk); #1;
    end
    tests++;
    if (extra !== 0) begin
      fails++; $display("FAIL hold_single_pulse extra ready cycles got %0d want 0", extra);
    end
    txn(0, 1'b0, 4'h4, 4'h0, "hold_rd4");
    txn(0, 1'b0, 4'h9, 4'h0, "hold_rd9");
  endtask

  task automatic test_reset_mid();
    int seen;
    valid_s[0] = 1'b1; write_s[0] = 1'b1; addr_s[0] = 4'h2; wdata_s[0] = 4'h7;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    valid_s[0] = 1'b0;
    tests++;
    if (ready_s[0] !== 1'b0 || rdata_s[0] !== 4'h0) begin
      fails++; $display("FAIL midrst_outputs ready/rdata got %b/%h want 0/0", ready_s[0], rdata_s[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (ready_s[0] === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL midrst_no_ready ready cycles got %0d want 0", seen);
    end
    txn(0, 1'b0, 4'h2, 4'h0, "midrst_rd2");
    txn(0, 1'b0, 4'h3, 4'h0, "midrst_rd3");
  endtask

  task automatic test_status();
    for (int i = 0; i < 17; i++) begin
      txn(1, 1'b1, 4'(i % 15), 4'(i), "stat_fill");
    end
    txn(1, 1'b0, 4'hF, 4'h0, "stat_rd1");
    txn(1, 1'b1, 4'hF, 4'h9, "stat_wr");
    txn(1, 1'b0, 4'hF, 4'h0, "stat_rd2");
    txn(1, 1'b0, 4'h1, 4'h0, "stat_rd_reg1");
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_zero_wait();
    test_back_to_back();
    test_hold();
    test_reset_mid();
    test_status();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bus_wait_slave.md
Name: bus_wait_slave

Overview:
- Sequential bus slave on the valid/addr/wdata/rdata/ready bus, sitting directly downstream of the bus master and consuming its requests.
- Replaces the zero-latency combinational echo slave with a 16 x 4-bit register file.
- Responds after a programmable number of wait states, so masters can be exercised against real handshake latency.
- Exposes a 5-bit bus_out status word for the parent to OR into its summary output.

Parameters:
- WAIT_CYCLES, 2, wait-state cycles between request accept and the ready pulse (0..15 legal).
- ADDR_W, 4, address width; register file depth is 2**ADDR_W.
- DATA_W, 4, data width of wdata, rdata and each register.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- valid  input  1  request from master; held high until ready is seen.
- write  input  1  1 = write, 0 = read; sampled with valid.
- addr  input  ADDR_W  register index; sampled at accept.
- wdata  input  DATA_W  write data; sampled at accept.
- rdata  output  DATA_W  read data; meaningful in the ready cycle.
- ready  output  1  one-cycle completion pulse.
- bus_out  output  DATA_W+1  registered {ready, rdata}.

Behaviour:
- One clock domain; reset is asynchronous, active-low.
- Reset (rst_n low, any time, including mid-transaction):
  - FSM goes to IDLE and the wait counter clears to 0.
  - All registers clear to 0.
  - rdata=0, ready=0, bus_out=0.
  - Any in-flight transaction is dropped, with no write and no ready.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - valid=1 accepts the request: capture write, addr and wdata into internal registers and load the counter with WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise RESP.
- WAIT:
  - Counter decrements by 1 each cycle.
  - When the counter reaches 1, next state is RESP.
  - Total cycles spent in WAIT = WAIT_CYCLES.
- RESP:
  - Lasts exactly one cycle; ready=1 and rdata is driven. Next state is IDLE.
- Read: rdata = the captured-address register value, as of the RESP cycle.
- Write: the register is updated at the end of the RESP cycle, and rdata reflects the new wdata in that cycle (write-through echo).
- Latency: accept edge to ready high = WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, ready is asserted in the cycle after accept.
- Outside RESP: rdata=0 and ready=0.
- Input hold rules:
  - Changes on addr, wdata or write after accept are ignored.
  - valid dropping before ready does not abort; the transaction still completes and ready pulses.
- Back-to-back: the earliest next accept is in the IDLE cycle right after RESP. A valid still high in that cycle is treated as a new request, so masters must drop valid on seeing ready.
- bus_out: registered copy of {ready, rdata}, one cycle after ready/rdata; 0 otherwise.
- Arithmetic: the counter is wide enough for WAIT_CYCLES with no wrap; addresses are never out of range (full depth).

Optional Feature:
- Macro: BUS_WAIT_SLAVE_STATUS_EN.
- Defined:
  - Address 2**ADDR_W-1 becomes a read-only status register.
  - It holds a completed-transaction counter, DATA_W bits, which increments on every ready pulse and wraps from all-ones to 0.
  - Writes to that address complete normally (ready pulses, rdata echoes wdata) but do not change storage.
  - Reads return the count as it stood before the current transaction.
  - The counter resets to 0.
- Undefined: that address is an ordinary register and no counter is present.

Test Plan:
- Reset, then write addr=3 wdata=0xA with WAIT_CYCLES=2 -> ready high exactly 3 cycles after accept, rdata=0xA; bus_out=0x1A the following cycle.
- Read addr=3 after the previous write -> rdata=0xA at ready; read of unwritten addr=5 -> rdata=0x0.
- WAIT_CYCLES=0 build: valid at cycle N -> ready at N+1; back-to-back write 7/0x5 then read 7 -> rdata=0x5 on the second ready.
- Change addr and wdata, and drop valid, during WAIT -> completion uses the originally captured values; ready still pulses once.
- Assert rst_n=0 during WAIT of a write to addr=2 -> ready never pulses; a subsequent read of addr 2 returns 0.
- BUS_WAIT_SLAVE_STATUS_EN: 17 completed transactions, then read addr=0xF -> rdata=0x1 (count 17 wraps to 1); a write of 0x9 to 0xF leaves the count unaffected.
